write_back_unit: RTL and testbench
==================================

# write_back_unit

Writeback stage of the pipelined processor. Accepts one retiring instruction per cycle from the MEM/WB pipeline register and drives the write port of the decode-stage register file (`register_write`, `write_addr`, `write_data`). Dual-destination instructions (SWAP-class) need two register writes. For these the block sequences the writes over two cycles and back-pressures MEM/WB with `wb_ready`. All register-file-facing outputs are registered.

## Interface
Parameters:
- `DATA_W`, 16, register data width
- `ADDR_W`, 3, register address width (8 registers)

Ports:
- `clk`  in  1  single clock; all state updates on posedge
- `reset`  in  1  asynchronous, active-high reset
- `wb_valid`  in  1  MEM/WB holds a retiring instruction
- `wb_ready`  out  1  block can accept this cycle; combinational, equals (state == IDLE)
- `wb_reg_write`  in  1  instruction writes at least one register
- `wb_mem_to_reg`  in  1  first write takes `mem_data` (1) or `alu_result` (0)
- `wb_dual`  in  1  instruction writes a second register
- `wb_dst1`  in  ADDR_W  first destination register
- `wb_dst2`  in  ADDR_W  second destination register
- `alu_result`  in  DATA_W  ALU result
- `mem_data`  in  DATA_W  load data
- `wb_data2`  in  DATA_W  value for second destination
- `register_write`  out  1  write enable to register file
- `write_addr`  out  ADDR_W  register file write address
- `write_data`  out  DATA_W  register file write data
- `wr_count`  out  16  retired-write counter (see Configuration)

## Operation
- Accept = `wb_valid && wb_ready`, sampled at posedge.
- FSM states:
  - IDLE: accepting.
  - SECOND: the second write is pending.
- IDLE, accept, `wb_reg_write=1`:
  - Next-cycle outputs: `register_write=1`, `write_addr=wb_dst1`, `write_data = wb_mem_to_reg ? mem_data : alu_result`.
  - If `wb_dual=1`: latch `wb_dst2` and `wb_data2` into holding registers, then go to SECOND.
- IDLE, accept, `wb_reg_write=0`: next-cycle `register_write=0`. `wb_dual` is ignored. Stay in IDLE.
- IDLE, no accept: next-cycle `register_write=0`. `write_addr` and `write_data` hold their previous values.
- SECOND, unconditionally at the next edge:
  - Outputs: `register_write=1`, `write_addr` = held dst2, `write_data` = held data2.
  - Go to IDLE.
  - Inputs are ignored, because `wb_ready=0`.
- Both writes of a dual instruction can target the same register (`wb_dst1 == wb_dst2`). Both are issued in order, so `wb_data2` is the final register value.
- Reset, asynchronous:
  - State goes to IDLE and `wb_ready=1`.
  - `register_write=0`, `write_addr=0`, `write_data=0`, holding registers cleared, `wr_count=0`.
  - Reset asserted while in SECOND drops the pending second write.

## Timing
- Single-write latency: accepted at edge N. Outputs are valid after edge N. The register file commits at edge N+1.
- Dual write:
  - First write is presented after edge N and commits at N+1.
  - Second write is presented after edge N+1 and commits at N+2.
  - `wb_ready=0` from after edge N until after edge N+1. The next instruction can be accepted at edge N+2 at the earliest.
- Throughput: 1 instruction/cycle for single writes, 1 per 2 cycles for dual writes.
- `register_write` is high for exactly one cycle per issued write. Back-to-back single writes give continuous `register_write=1`.
- Outputs change only on posedge `clk` or on assertion of `reset`. They are glitch-free to the register file.

## Configuration
- Macro: `WB_WRITE_COUNT_EN`.
- Defined:
  - `wr_count` increments by 1 at every edge where the registered `register_write` becomes 1, which is once per issued write (a dual instruction counts 2).
  - Wraps 0xFFFF -> 0x0000.
  - Cleared by `reset`.
- Not defined: the `wr_count` port still exists and is tied to 0. No counter flops are synthesized.

## Test plan
- Reset then idle: assert `reset` mid-cycle -> outputs 0 immediately, `wb_ready=1`. Release reset with `wb_valid=0` for 3 cycles -> `register_write` stays 0.
- Single ALU write: `wb_dst1=2`, `alu_result=0x1234`, `wb_mem_to_reg=0` -> next cycle `register_write=1`, `write_addr=2`, `write_data=0x1234`. One cycle later `register_write=0`.
- Load then ALU back-to-back: cycle 0 `dst1=3`, `mem_data=0xBEEF`, `mem_to_reg=1`; cycle 1 `dst1=7`, `alu_result=0x0042` -> `register_write=1` for two consecutive cycles with (3, 0xBEEF) then (7, 0x0042). `wb_ready` stays 1.
- Dual write: `dst1=1`, `alu_result=0x00AA`, `dst2=4`, `wb_data2=0x5555`, `wb_dual=1`, with a second instruction held on the inputs -> writes (1, 0x00AA) then (4, 0x5555). `wb_ready=0` for one cycle. The held instruction is written in the third cycle.
- Reset in SECOND: start the dual write above, then assert `reset` after the first write is presented -> the second write is never issued, `register_write=0`, `wr_count=0` (`WB_WRITE_COUNT_EN`).
- Counter wrap (`WB_WRITE_COUNT_EN`): 65535 single writes -> `wr_count=0xFFFF`; one more write -> 0x0000. Without the macro -> `wr_count` stays 0 throughout.

Source files
------------

// File: rtl/write_back_unit_if.sv
// MEM/WB -> writeback handshake bus.
interface write_back_unit_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
);
  logic              wb_valid;
  logic              wb_ready;
  logic              wb_reg_write;
  logic              wb_mem_to_reg;
  logic              wb_dual;
  logic [ADDR_W-1:0] wb_dst1;
  logic [ADDR_W-1:0] wb_dst2;
  logic [DATA_W-1:0] alu_result;
  logic [DATA_W-1:0] mem_data;
  logic [DATA_W-1:0] wb_data2;

  modport master (
    output wb_valid, wb_reg_write, wb_mem_to_reg, wb_dual,
    output wb_dst1, wb_dst2, alu_result, mem_data, wb_data2,
    input  wb_ready
  );

  modport slave (
    input  wb_valid, wb_reg_write, wb_mem_to_reg, wb_dual,
    input  wb_dst1, wb_dst2, alu_result, mem_data, wb_data2,
    output wb_ready
  );
endinterface

// File: rtl/write_back_unit.sv
// Writeback stage: drives the register-file write port, splitting
// dual-destination instructions into two sequential writes.
// Optional feature macro: WB_WRITE_COUNT_EN (retired-write counter on wr_count).
module write_back_unit #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  write_back_unit_if.slave  wb,
  output logic              register_write,
  output logic [ADDR_W-1:0] write_addr,
  output logic [DATA_W-1:0] write_data,
  output logic [15:0]       wr_count
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t            state_q, state_d;
  logic              rw_d;
  logic [ADDR_W-1:0] addr_d, hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0] data_d, hold_data_q, hold_data_d;

  assign wb.wb_ready = (state_q == IDLE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q        <= IDLE;
      register_write <= 1'b0;
      write_addr     <= '0;
      write_data     <= '0;
      hold_addr_q    <= '0;
      hold_data_q    <= '0;
    end else begin
      state_q        <= state_d;
      register_write <= rw_d;
      write_addr     <= addr_d;
      write_data     <= data_d;
      hold_addr_q    <= hold_addr_d;
      hold_data_q    <= hold_data_d;
    end
  end

  // Next-state and next registered outputs; address/data hold when no write issues.
  always_comb begin
    state_d     = state_q;
    rw_d        = 1'b0;
    addr_d      = write_addr;
    data_d      = write_data;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    case (state_q)
      IDLE: begin
        if (wb.wb_valid && wb.wb_reg_write) begin
          rw_d   = 1'b1;
          addr_d = wb.wb_dst1;
          data_d = wb.wb_mem_to_reg ? wb.mem_data : wb.alu_result;
          if (wb.wb_dual) begin
            hold_addr_d = wb.wb_dst2;
            hold_data_d = wb.wb_data2;
            state_d     = SECOND;
          end
        end
      end
      SECOND: begin
        rw_d    = 1'b1;
        addr_d  = hold_addr_q;
        data_d  = hold_data_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef WB_WRITE_COUNT_EN
  // Counts with the next-state write enable so it steps on the edge register_write rises for each write.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) wr_count <= '0;
    else if (rw_d) wr_count <= wr_count + 16'd1;
  end
`else
  assign wr_count = '0;
`endif

endmodule

// File: tb/tb_write_back_unit.sv
// Directed bench for write_back_unit with a queue scoreboard of expected outputs.
module tb_write_back_unit;

  logic        clk;
  logic        reset;
  logic        register_write;
  logic [2:0]  write_addr;
  logic [15:0] write_data;
  logic [15:0] wr_count;

  int total = 0;
  int bad   = 0;

  write_back_unit_if #(.DATA_W(16), .ADDR_W(3)) bus ();

  write_back_unit #(.DATA_W(16), .ADDR_W(3)) dut (
    .clk            (clk),
    .reset          (reset),
    .wb             (bus.slave),
    .register_write (register_write),
    .write_addr     (write_addr),
    .write_data     (write_data),
    .wr_count       (wr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [2:0]  addr;
    logic [15:0] data;
    logic [15:0] cnt;
  } exp_t;

  exp_t sb[$];

  // reference model state
  logic        m_second;
  logic [2:0]  m_haddr, m_addr;
  logic [15:0] m_hdata, m_data, m_count;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_cnt();
`ifdef WB_WRITE_COUNT_EN
    return m_count;
`else
    return 16'h0;
`endif
  endfunction

  // Called at negedge: drive one cycle of inputs, predict, clock, compare.
  task automatic step(input logic v, input logic rw, input logic m2r, input logic dual,
                      input logic [2:0] d1, input logic [2:0] d2,
                      input logic [15:0] alu, input logic [15:0] mem, input logic [15:0] dat2);
    exp_t e, o;
    bus.wb_valid      = v;
    bus.wb_reg_write  = rw;
    bus.wb_mem_to_reg = m2r;
    bus.wb_dual       = dual;
    bus.wb_dst1       = d1;
    bus.wb_dst2       = d2;
    bus.alu_result    = alu;
    bus.mem_data      = mem;
    bus.wb_data2      = dat2;
    chk("wb_ready", {31'b0, bus.wb_ready}, {31'b0, ~m_second});
    if (m_second) begin
      e.rw = 1'b1; e.addr = m_haddr; e.data = m_hdata;
      m_second = 1'b0;
    end else if (v && rw) begin
      e.rw = 1'b1; e.addr = d1; e.data = m2r ? mem : alu;
      if (dual) begin
        m_haddr = d2; m_hdata = dat2; m_second = 1'b1;
      end
    end else begin
      e.rw = 1'b0; e.addr = m_addr; e.data = m_data;
    end
    m_addr = e.addr;
    m_data = e.data;
    if (e.rw) m_count = m_count + 16'd1;
    e.cnt = exp_cnt();
    sb.push_back(e);
    @(posedge clk);
    @(negedge clk);
    if (sb.size() == 0) begin
      chk("sb_empty", 32'd0, 32'd1);
    end else begin
      o = sb.pop_front();
      chk("register_write", {31'b0, register_write}, {31'b0, o.rw});
      chk("write_addr", {29'b0, write_addr}, {29'b0, o.addr});
      chk("write_data", {16'b0, write_data}, {16'b0, o.data});
      chk("wr_count", {16'b0, wr_count}, {16'b0, o.cnt});
    end
  endtask

  task automatic idle_step();
    step(1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0);
  endtask

  // Asserts reset mid-cycle, checks the asynchronous clear, releases at the next negedge.
  task automatic do_reset(input string tag);
    bus.wb_valid = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk({tag, "_rw"},    {31'b0, register_write}, 32'd0);
    chk({tag, "_addr"},  {29'b0, write_addr}, 32'd0);
    chk({tag, "_data"},  {16'b0, write_data}, 32'd0);
    chk({tag, "_ready"}, {31'b0, bus.wb_ready}, 32'd1);
    chk({tag, "_cnt"},   {16'b0, wr_count}, 32'd0);
    sb.delete();
    m_second = 1'b0; m_haddr = '0; m_hdata = '0;
    m_addr = '0; m_data = '0; m_count = '0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b0;
    bus.wb_valid = 1'b0; bus.wb_reg_write = 1'b0; bus.wb_mem_to_reg = 1'b0;
    bus.wb_dual = 1'b0; bus.wb_dst1 = '0; bus.wb_dst2 = '0;
    bus.alu_result = '0; bus.mem_data = '0; bus.wb_data2 = '0;

    // reset then idle
    do_reset("rst0");
    repeat (3) idle_step();

    // single ALU write, then idle
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd2, 3'd0, 16'h1234, 16'h0, 16'h0);
    idle_step();

    // load then ALU back-to-back
    step(1'b1, 1'b1, 1'b1, 1'b0, 3'd3, 3'd0, 16'h0, 16'hBEEF, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd7, 3'd0, 16'h0042, 16'h0, 16'h0);

    // accepted but no register write; wb_dual must be ignored
    step(1'b1, 1'b0, 1'b0, 1'b1, 3'd5, 3'd6, 16'hDEAD, 16'h0, 16'hCAFE);
    idle_step();

    // dual write with next instruction held on the inputs
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd4, 16'h00AA, 16'h0, 16'h5555);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 16'h0777, 16'h0, 16'h0);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd6, 3'd0, 16'h0777, 16'h0, 16'h0);
    idle_step();

    // dual write to the same register: second value lands last
    step(1'b1, 1'b1, 1'b1, 1'b1, 3'd5, 3'd5, 16'h0, 16'h1111, 16'h2222);
    idle_step();
    idle_step();

    // reset while the second write is pending
    step(1'b1, 1'b1, 1'b0, 1'b1, 3'd1, 3'd4, 16'h00AA, 16'h0, 16'h5555);
    do_reset("rst_second");
    idle_step();
    idle_step();

`ifdef WB_WRITE_COUNT_EN
    // counter wrap
    for (int unsigned i = 0; i < 65535; i++)
      step(1'b1, 1'b1, 1'b0, 1'b0, 3'(i), 3'd0, 16'(i), 16'h0, 16'h0);
    chk("cnt_ffff", {16'b0, wr_count}, 32'h0000FFFF);
    step(1'b1, 1'b1, 1'b0, 1'b0, 3'd3, 3'd0, 16'hABCD, 16'h0, 16'h0);
    chk("cnt_wrap", {16'b0, wr_count}, 32'h00000000);
`else
    for (int unsigned i = 0; i < 40; i++)
      step(1'b1, 1'b1, i[0], 1'b0, 3'(i), 3'd0, 16'(i * 3), 16'(i * 5), 16'h0);
    chk("cnt_tied", {16'b0, wr_count}, 32'd0);
`endif
    idle_step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
